// File: rtl/capture_pkg.sv
// capture_pkg
//   Definitions shared by input_capture and its downstream consumers:
//   the handshake FSM state encoding and the default capture counter width.
package capture_pkg;

    // Default width of the capture counter value and of every period output.
    localparam int CAP_WIDTH = 8;

    // Handshake states of the capture consumer.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2,
        UPDATE   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/capture_period_meter_if.sv
// capture_period_meter_if
//   Handshake bundle between the input_capture unit and its consumer.
//   Signals:
//     val        - captured counter value, held while intFlag is high
//     intFlag    - capture interrupt, level, held until acknowledged
//     rstIntFlag - acknowledge pulse back to the capture unit
//     rstVal     - clear pulse for the capture unit's held value
//   Modports:
//     master - the capture unit side (drives val/intFlag)
//     slave  - the consumer side (drives rstIntFlag/rstVal)
interface capture_period_meter_if
    import capture_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH
);

    logic [WIDTH-1:0] val;
    logic             intFlag;
    logic             rstIntFlag;
    logic             rstVal;

    modport master (
        output val,
        output intFlag,
        input  rstIntFlag,
        input  rstVal
    );

    modport slave (
        input  val,
        input  intFlag,
        output rstIntFlag,
        output rstVal
    );

endinterface

// File: rtl/period_minmax.sv
// period_minmax
//   Running minimum/maximum of the measured periods, compared as unsigned.
//   Ports:
//     clk, rst - clock and synchronous active-high reset
//     clr      - restart tracking (min to all ones, max to zero)
//     upd      - fold 'value' into the running min/max this cycle
//     value    - newly computed period
//     min_val  - smallest period seen since reset/clear
//     max_val  - largest period seen since reset/clear
module period_minmax
    import capture_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val
);

    // Min starts at all ones and max at zero so the first period becomes both.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min_val <= '1;
            max_val <= '0;
        end else if (upd) begin
            if (value < min_val) begin
                min_val <= value;
            end
            if (value > max_val) begin
                max_val <= value;
            end
        end
    end

endmodule

// File: rtl/capture_period_meter.sv
// capture_period_meter
//   Services the input_capture interrupt: latches the captured value,
//   acknowledges it with rstIntFlag, and measures the modulo-2^WIDTH period
//   between successive captures with running min/max tracking. A host clear
//   restarts the measurement and pulses rstVal to the capture unit.
//   Ports:
//     clk, rst     - clock and synchronous active-high reset
//     cap          - capture unit handshake (slave side)
//     en           - measurement enable, only gates the start of a capture
//     clr          - host clear request, single-cycle pulse
//     period       - last computed period
//     period_valid - one-cycle strobe when period is updated
//     period_min   - smallest period since reset/clear
//     period_max   - largest period since reset/clear
//     ack_err      - sticky: intFlag did not drop within ACK_TIMEOUT cycles
module capture_period_meter
    import capture_pkg::*;
#(
    parameter int WIDTH       = CAP_WIDTH,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    capture_period_meter_if.slave   cap,
    input  logic                    en,
    input  logic                    clr,
    output logic [WIDTH-1:0]        period,
    output logic                    period_valid,
    output logic [WIDTH-1:0]        period_min,
    output logic [WIDTH-1:0]        period_max,
    output logic                    ack_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    cap_state_t       state;
    cap_state_t       next_state;
    logic             timeout;
    logic [CW-1:0]    tmo_cnt;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev;
    logic             have_prev;
    logic [WIDTH-1:0] diff;
    logic             minmax_upd;

    // Borrow is dropped, so a counter wrap between captures still measures right.
    assign diff       = cur - prev;
    assign minmax_upd = (state == UPDATE) && have_prev && !clr;

    // Next-state logic; a clear request overrides whatever the FSM would do.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (en && cap.intFlag) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!cap.intFlag) begin
                    next_state = UPDATE;
                end else if (tmo_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    next_state = ACK;
                    timeout    = 1'b1;
                end
            end
            UPDATE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (clr) begin
            next_state = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath and registered outputs. rstIntFlag is registered from the
    // next state so it is high exactly during each ACK cycle, including the
    // re-acknowledge after a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= '0;
            prev         <= '0;
            have_prev    <= 1'b0;
            tmo_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            ack_err      <= 1'b0;
            cap.rstIntFlag <= 1'b0;
            cap.rstVal     <= 1'b0;
        end else begin
            period_valid   <= 1'b0;
            cap.rstVal     <= clr;
            cap.rstIntFlag <= (next_state == ACK);
            if (clr) begin
                have_prev <= 1'b0;
                ack_err   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en && cap.intFlag) begin
                            cur <= cap.val;
                        end
                    end
                    ACK: begin
                        tmo_cnt <= '0;
                    end
                    WAIT_CLR: begin
                        if (cap.intFlag) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if (timeout) begin
                                ack_err <= 1'b1;
                            end
                        end
                    end
                    UPDATE: begin
                        if (have_prev) begin
                            period       <= diff;
                            period_valid <= 1'b1;
                        end
                        prev      <= cur;
                        have_prev <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    period_minmax #(
        .WIDTH (WIDTH)
    ) u_minmax (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .upd     (minmax_upd),
        .value   (diff),
        .min_val (period_min),
        .max_val (period_max)
    );

endmodule

// File: tb/tb_capture_period_meter.sv
// tb_capture_period_meter
//   Directed bench for capture_period_meter. The main process plays the
//   capture unit; a compare process checks every cycle against a
//   transaction-level model of captured values and resulting periods.
module tb_capture_period_meter;

    localparam int WIDTH       = 8;
    localparam int ACK_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic [WIDTH-1:0] period_min;
    logic [WIDTH-1:0] period_max;
    logic             ack_err;

    capture_period_meter_if #(.WIDTH(WIDTH)) cap_bus ();

    capture_period_meter #(
        .WIDTH       (WIDTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cap          (cap_bus),
        .en           (en),
        .clr          (clr),
        .period       (period),
        .period_valid (period_valid),
        .period_min   (period_min),
        .period_max   (period_max),
        .ack_err      (ack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] mn;
        logic [WIDTH-1:0] mx;
    } exp_t;

    exp_t             expQ[$];
    int               nCompared = 0;
    int               nMismatch = 0;
    bit               checking  = 1'b0;
    int               ackCount  = 0;
    int               cycleCnt  = 0;
    int               ackTimes[$];

    // Model of the measurement: which captures were serviced and what follows.
    bit               mHavePrev;
    logic [WIDTH-1:0] mPrev;
    logic [WIDTH-1:0] mMinRun;
    logic [WIDTH-1:0] mMaxRun;

    // Committed output values as seen by the compare process.
    logic [WIDTH-1:0] cPeriod;
    logic [WIDTH-1:0] cMin;
    logic [WIDTH-1:0] cMax;
    exp_t             cEntry;
    bit               rstPrev = 1'b1;
    bit               clrPrev = 1'b0;
    bit               pvPrev  = 1'b0;
    bit               ackPrev = 1'b0;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    function automatic void modelClear();
        mHavePrev = 1'b0;
        mPrev     = '0;
        mMinRun   = '1;
        mMaxRun   = '0;
    endfunction

    // A serviced capture yields a period only when an earlier one exists.
    function automatic void modelCapture(input logic [WIDTH-1:0] v);
        int   d;
        exp_t e;
        if (mHavePrev) begin
            d = (int'(v) - int'(mPrev) + (1 << WIDTH)) % (1 << WIDTH);
            e.p  = WIDTH'(d);
            e.mn = (e.p < mMinRun) ? e.p : mMinRun;
            e.mx = (e.p > mMaxRun) ? e.p : mMaxRun;
            mMinRun = e.mn;
            mMaxRun = e.mx;
            expQ.push_back(e);
        end
        mPrev     = v;
        mHavePrev = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a capture, clear the flag once acknowledged (or after holdTicks
    // cycles when the flag is stuck), then let the handshake finish.
    task automatic applyStimulus(input logic [WIDTH-1:0] v, input int holdTicks,
                                 input bit dropEn);
        int t;
        bit seen;
        modelCapture(v);
        cap_bus.val     = v;
        cap_bus.intFlag = 1'b1;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 20) begin
            tick();
            t++;
            if (cap_bus.rstIntFlag === 1'b1) seen = 1'b1;
        end
        checkOutput("ack_seen", 32'(seen), 32'd1);
        if (dropEn) en = 1'b0;
        while (t < holdTicks) begin
            tick();
            t++;
        end
        cap_bus.intFlag = 1'b0;
        repeat (4) tick();
        en = 1'b1;
    endtask

    // Compare process: checks committed outputs every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                cycleCnt++;
                if (rstPrev) begin
                    cPeriod = '0;
                    cMin    = '1;
                    cMax    = '0;
                    expQ.delete();
                    checkOutput("rst_rstIntFlag", 32'(cap_bus.rstIntFlag), 32'd0);
                    checkOutput("rst_period_valid", 32'(period_valid), 32'd0);
                    checkOutput("rst_ack_err", 32'(ack_err), 32'd0);
                end else if (clrPrev) begin
                    cMin = '1;
                    cMax = '0;
                    checkOutput("clr_ack_err", 32'(ack_err), 32'd0);
                end
                if (period_valid === 1'b1) begin
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nMismatch++;
                        $display("[TB] FAIL unexpected_period_valid: got 1, expected 0 (period 0x%0h)",
                                 period);
                    end else begin
                        cEntry  = expQ.pop_front();
                        cPeriod = cEntry.p;
                        cMin    = cEntry.mn;
                        cMax    = cEntry.mx;
                    end
                end
                checkOutput("period", 32'(period), 32'(cPeriod));
                checkOutput("period_min", 32'(period_min), 32'(cMin));
                checkOutput("period_max", 32'(period_max), 32'(cMax));
                checkOutput("rstVal", 32'(cap_bus.rstVal), 32'(clrPrev && !rstPrev));
                if (pvPrev) checkOutput("pv_back_to_back", 32'(period_valid), 32'd0);
                if (ackPrev) checkOutput("ack_back_to_back", 32'(cap_bus.rstIntFlag), 32'd0);
                if (cap_bus.rstIntFlag === 1'b1) begin
                    ackCount++;
                    ackTimes.push_back(cycleCnt);
                end
                rstPrev = rst;
                clrPrev = clr;
                pvPrev  = period_valid;
                ackPrev = cap_bus.rstIntFlag;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        rst             = 1'b1;
        en              = 1'b0;
        clr             = 1'b0;
        cap_bus.val     = '0;
        cap_bus.intFlag = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        modelClear();
        checking = 1'b1;
        tick();

        // Reset values, hand-computed.
        checkOutput("init_rstIntFlag", 32'(cap_bus.rstIntFlag), 32'd0);
        checkOutput("init_rstVal", 32'(cap_bus.rstVal), 32'd0);
        checkOutput("init_period", 32'(period), 32'h00);
        checkOutput("init_period_valid", 32'(period_valid), 32'd0);
        checkOutput("init_min", 32'(period_min), 32'hFF);
        checkOutput("init_max", 32'(period_max), 32'h00);
        checkOutput("init_ack_err", 32'(ack_err), 32'd0);

        // Two normal captures: 0x10 then 0x30.
        en = 1'b1;
        a0 = ackCount;
        applyStimulus(8'h10, 0, 1'b0);
        applyStimulus(8'h30, 0, 1'b0);
        checkOutput("two_acks", 32'(ackCount - a0), 32'd2);
        checkOutput("basic_period", 32'(period), 32'h20);
        checkOutput("basic_min", 32'(period_min), 32'h20);
        checkOutput("basic_max", 32'(period_max), 32'h20);

        // Wrap-around: 0x30 -> 0xF0 (0xC0), 0xF0 -> 0x10 (0x20), 0x10 -> 0x10 (0x00).
        applyStimulus(8'hF0, 0, 1'b0);
        applyStimulus(8'h10, 0, 1'b0);
        checkOutput("wrap_period", 32'(period), 32'h20);
        checkOutput("wrap_max", 32'(period_max), 32'hC0);
        applyStimulus(8'h10, 0, 1'b1);
        checkOutput("zero_period", 32'(period), 32'h00);
        checkOutput("zero_min", 32'(period_min), 32'h00);

        // Stuck flag for 40 cycles: re-acks 16 cycles apart, then 0x10 -> 0x70.
        ackTimes.delete();
        a0 = ackCount;
        applyStimulus(8'h70, 40, 1'b0);
        checkOutput("stuck_acks", 32'(ackCount - a0), 32'd3);
        if (ackTimes.size() >= 3) begin
            checkOutput("stuck_spacing1", 32'(ackTimes[1] - ackTimes[0]), 32'd16);
            checkOutput("stuck_spacing2", 32'(ackTimes[2] - ackTimes[1]), 32'd16);
        end
        checkOutput("stuck_ack_err", 32'(ack_err), 32'd1);
        checkOutput("stuck_period", 32'(period), 32'h60);

        // Clear during WAIT_CLR with the flag still high: the capture is
        // discarded and re-serviced from IDLE with no period.
        cap_bus.val     = 8'h50;
        cap_bus.intFlag = 1'b1;
        tick();
        checkOutput("clr_first_ack", 32'(cap_bus.rstIntFlag), 32'd1);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        modelClear();
        modelCapture(8'h50);
        checkOutput("clr_rstVal", 32'(cap_bus.rstVal), 32'd1);
        checkOutput("clr_ack_err_lit", 32'(ack_err), 32'd0);
        checkOutput("clr_min", 32'(period_min), 32'hFF);
        checkOutput("clr_max", 32'(period_max), 32'h00);
        tick();
        checkOutput("reservice_ack", 32'(cap_bus.rstIntFlag), 32'd1);
        checkOutput("rstVal_one_cycle", 32'(cap_bus.rstVal), 32'd0);
        cap_bus.intFlag = 1'b0;
        repeat (4) tick();
        checkOutput("clr_period_kept", 32'(period), 32'h60);
        applyStimulus(8'h58, 0, 1'b0);
        checkOutput("after_clr_period", 32'(period), 32'h08);
        checkOutput("after_clr_min", 32'(period_min), 32'h08);
        checkOutput("after_clr_max", 32'(period_max), 32'h08);

        // en low blocks the capture; raising it services within one cycle;
        // reset during ACK drops rstIntFlag and restores reset values.
        en              = 1'b0;
        cap_bus.val     = 8'h90;
        cap_bus.intFlag = 1'b1;
        a0 = ackCount;
        repeat (5) tick();
        checkOutput("en_blocked", 32'(ackCount - a0), 32'd0);
        en = 1'b1;
        tick();
        checkOutput("en_ack", 32'(cap_bus.rstIntFlag), 32'd1);
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        cap_bus.intFlag = 1'b0;
        modelClear();
        checkOutput("rst_ack_dropped", 32'(cap_bus.rstIntFlag), 32'd0);
        checkOutput("rst_period", 32'(period), 32'h00);
        checkOutput("rst_min", 32'(period_min), 32'hFF);
        repeat (5) tick();

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
